// File: rtl/reg_file_2r1w_pkg.sv
// Shared definitions for the 2-read/1-write register file: clear-FSM state
// encoding and the address range qualifier used by both read and write paths.
package reg_file_2r1w_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // True when addr names a real entry; DEPTH need not be a power of two,
  // so the top codes of the address space may be unpopulated.
  function automatic logic addr_ok(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/reg_file_2r1w_if.sv
// Bus bundle of the register file: write port, two read ports, clear request
// and the busy flag. The master is the control side, the slave the bank.
interface reg_file_2r1w_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              wr_en;
  logic [ADDR_W-1:0] w_addr;
  logic [WIDTH-1:0]  w_data;
  logic [ADDR_W-1:0] r_addr0;
  logic [WIDTH-1:0]  r_data0;
  logic [ADDR_W-1:0] r_addr1;
  logic [WIDTH-1:0]  r_data1;
  logic              clr_req;
  logic              busy;

  modport master (
    output wr_en, w_addr, w_data, r_addr0, r_addr1, clr_req,
    input  r_data0, r_data1, busy
  );

  modport slave (
    input  wr_en, w_addr, w_data, r_addr0, r_addr1, clr_req,
    output r_data0, r_data1, busy
  );

endinterface

// File: rtl/reg_file_2r1w_rd_port.sv
// One combinational read port: range check, zero forcing during a sweep or
// for the hardwired-zero entry, optional write-to-read bypass, array mux.
module reg_file_rd_port
  import reg_file_2r1w_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              busy_i,
  input  logic [ADDR_W-1:0] r_addr_i,
  input  logic              byp_vld_i,
  input  logic [ADDR_W-1:0] w_addr_i,
  input  logic [WIDTH-1:0]  w_data_i,
  input  logic [WIDTH-1:0]  mem_i [DEPTH],
  output logic [WIDTH-1:0]  r_data_o
);

  // Priority mux: anything that should read as zero wins over bypass/array.
  // byp_vld_i is already qualified, so a dropped write never forwards.
  always_comb begin
    r_data_o = '0;
    if (busy_i) begin
      r_data_o = '0;
    end else if (!addr_ok(32'(r_addr_i), DEPTH)) begin
      r_data_o = '0;
    end else if ((ZERO_REG != 0) && (r_addr_i == '0)) begin
      r_data_o = '0;
    end else if ((BYPASS != 0) && byp_vld_i && (w_addr_i == r_addr_i)) begin
      r_data_o = w_data_i;
    end else begin
      r_data_o = mem_i[r_addr_i];
    end
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// Datapath register bank: one write port, two combinational read ports and a
// clear sequencer that zeroes every entry after reset or on request.
module reg_file_2r1w
  import reg_file_2r1w_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic           clk,
  input  logic           reset,
  reg_file_2r1w_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);

  state_t            state_q;
  logic [ADDR_W-1:0] clr_ptr_q;
  logic              busy_q;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic              ptr_last;
  logic              wr_ok;

  // Write qualification: only in IDLE, in range, not entry 0 when it is
  // hardwired, and never in the cycle a clear request is accepted.
  always_comb begin
    ptr_last = (clr_ptr_q == ADDR_W'(DEPTH - 1));
    wr_ok    = (state_q == IDLE) && bus.wr_en && !bus.clr_req &&
               addr_ok(32'(bus.w_addr), DEPTH) &&
               !((ZERO_REG != 0) && (bus.w_addr == '0));
  end

  // Clear sequencer: reset or an accepted request starts a DEPTH-cycle sweep;
  // busy is registered alongside the state so it matches state==CLEAR.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.clr_req) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        CLEAR: begin
          if (ptr_last) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            clr_ptr_q <= clr_ptr_q + ADDR_W'(1);
          end
        end
      endcase
    end
  end

  // Array update: the sweep owns the array while clearing; the cycle reset
  // is asserted writes nothing because the sweep restarts at entry 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == CLEAR) begin
        mem_q[clr_ptr_q] <= '0;
      end else if (wr_ok) begin
        mem_q[bus.w_addr] <= bus.w_data;
      end
    end
  end

  assign bus.busy = busy_q;

  reg_file_rd_port #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .BYPASS  (BYPASS),
    .ZERO_REG(ZERO_REG)
  ) u_rd0 (
    .busy_i   (busy_q),
    .r_addr_i (bus.r_addr0),
    .byp_vld_i(wr_ok),
    .w_addr_i (bus.w_addr),
    .w_data_i (bus.w_data),
    .mem_i    (mem_q),
    .r_data_o (bus.r_data0)
  );

  reg_file_rd_port #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .BYPASS  (BYPASS),
    .ZERO_REG(ZERO_REG)
  ) u_rd1 (
    .busy_i   (busy_q),
    .r_addr_i (bus.r_addr1),
    .byp_vld_i(wr_ok),
    .w_addr_i (bus.w_addr),
    .w_data_i (bus.w_data),
    .mem_i    (mem_q),
    .r_data_o (bus.r_data1)
  );

endmodule
